// File: rtl/mem_arb_pkg.sv
// Shared encodings and the round-robin pick for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } arb_state_t;

    // True when master 1 should own the next transaction; on a tie the master
    // that did not finish last wins.
    function automatic logic pick_m1(input logic v0, input logic v1, input logic last_grant);
        return v1 && (!v0 || !last_grant);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating stall counter; expired is high on the last permitted stalled cycle.
module mem_arb_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear)
            count <= '0;
        else if (enable && count != CMAX)
            count <= count + CW'(1);
    end

    // A zero limit disables the watchdog entirely.
    assign expired = (LIMIT != 0) && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Round-robin arbiter sharing one picorv32 native memory port between two masters,
// with a watchdog that force-completes stalled transactions.
module mem_arbiter_2x1
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout_err
);

    arb_state_t state;
    logic       last_grant;

    logic        busy0, busy1, busy;
    logic        g_valid, g_instr;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;
    logic        wd_expired, timed_out, done;

    assign busy0 = (state == ST_BUSY0);
    assign busy1 = (state == ST_BUSY1);
    assign busy  = busy0 || busy1;

    assign g_valid = busy1 ? m1_valid : m0_valid;
    assign g_instr = busy1 ? m1_instr : m0_instr;
    assign g_addr  = busy1 ? m1_addr  : m0_addr;
    assign g_wdata = busy1 ? m1_wdata : m0_wdata;
    assign g_wstrb = busy1 ? m1_wstrb : m0_wstrb;

    // A real s_ready on the limit cycle takes precedence over the forced completion.
    assign timed_out = busy && g_valid && !s_ready && wd_expired;
    assign done      = busy && (!g_valid || s_ready || timed_out);

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (!busy || done),
        .enable  (busy && !s_ready),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid)
                        state <= pick_m1(m0_valid, m1_valid, last_grant) ? ST_BUSY1 : ST_BUSY0;
                end
                ST_BUSY0, ST_BUSY1: begin
                    // A dropped request abandons the grant without moving the round-robin pointer.
                    if (!g_valid) begin
                        state <= ST_IDLE;
                    end else if (s_ready || timed_out) begin
                        state      <= ST_IDLE;
                        last_grant <= busy1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        if (resetn && busy) begin
            s_valid     = g_valid && !timed_out;
            s_instr     = g_instr;
            s_addr      = g_addr;
            s_wdata     = g_wdata;
            s_wstrb     = g_wstrb;
            timeout_err = timed_out;
            if (busy0) begin
                m0_ready = s_ready || timed_out;
                m0_rdata = timed_out ? ERR_RDATA : s_rdata;
            end else begin
                m1_ready = s_ready || timed_out;
                m1_rdata = timed_out ? ERR_RDATA : s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed bench for mem_arbiter_2x1 with a per-cycle transaction-level reference model.
module tb_mem_arbiter_2x1;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_2x1 #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .timeout_err(timeout_err)
    );

    // Reference model: owner of the port (-1 none), who finished last, cycles spent in the grant.
    int          own = -1;
    int          last = 1;
    int          bc = 0;
    bit          armed = 0;
    logic        vx, tmo;
    logic [136:0] exp_v, act_v;
    logic        e_sv, e_si, e_r0, e_r1;
    logic [31:0] e_sa, e_sw, e_d0, e_d1;
    logic [3:0]  e_ss;

    always @(negedge clk) begin
        {e_sv, e_si, e_sa, e_sw, e_ss, e_r0, e_d0, e_r1, e_d1} = '0;
        vx = 1'b0;
        tmo = 1'b0;
        if (!resetn) armed = 1;
        if (resetn && own >= 0) begin
            vx   = (own == 1) ? m1_valid : m0_valid;
            tmo  = vx && !s_ready && (bc == TO - 1);
            e_sv = vx && !tmo;
            e_si = (own == 1) ? m1_instr : m0_instr;
            e_sa = (own == 1) ? m1_addr  : m0_addr;
            e_sw = (own == 1) ? m1_wdata : m0_wdata;
            e_ss = (own == 1) ? m1_wstrb : m0_wstrb;
            if (own == 0) begin e_r0 = s_ready || tmo; e_d0 = tmo ? ERR : s_rdata; end
            else          begin e_r1 = s_ready || tmo; e_d1 = tmo ? ERR : s_rdata; end
        end
        exp_v = {e_sv, e_si, e_sa, e_sw, e_ss, e_r0, e_d0, e_r1, e_d1, tmo};
        act_v = {s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata,
                 m1_ready, m1_rdata, timeout_err};
        if (armed) begin
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t: got %h want %h", $time, act_v, exp_v);
            end
        end
        if (!resetn) begin
            own = -1; last = 1; bc = 0;
        end else if (own < 0) begin
            bc = 0;
            if (m0_valid && m1_valid) own = (last == 1) ? 0 : 1;
            else if (m0_valid)        own = 0;
            else if (m1_valid)        own = 1;
        end else if (!vx) begin
            own = -1;
        end else if (s_ready || tmo) begin
            last = own; own = -1;
        end else begin
            bc++;
        end
    end

    always @(posedge clk)
        if (resetn && s_valid && s_ready && s_wstrb[0] && s_addr == 32'h1000_0000)
            $display("mem: uart '%c'", s_wdata[7:0]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        {m0_valid, m0_instr, m1_valid, m1_instr, s_ready} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata} = '0;
        m0_wstrb = '0;
        m1_wstrb = '0;
        repeat (5) tick();
        probe();
        chkb("rst_s_valid", s_valid, 1'b0);
        chkb("rst_m0_ready", m0_ready, 1'b0);
        tick();
        resetn = 1'b1;

        // m0 read, slave ready on the second BUSY cycle
        m0_valid = 1'b1; m0_addr = 32'h100; s_rdata = 32'h1234_5678;
        probe(); chkb("t1_idle_svalid", s_valid, 1'b0);
        tick();
        probe(); chkb("t1_svalid", s_valid, 1'b1); chk("t1_addr", s_addr, 32'h100);
        tick();
        s_ready = 1'b1;
        probe();
        chkb("t1_m0_ready", m0_ready, 1'b1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chkb("t1_m1_ready", m1_ready, 1'b0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        probe(); chkb("t1_after_ready", m0_ready, 1'b0);
        tick();

        // tie from reset, both held, slave always ready: m0,m1,m0,m1
        resetn = 1'b0; tick(); resetn = 1'b1;
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h200;
        m1_valid = 1'b1; m1_addr = 32'h300; s_ready = 1'b1; s_rdata = 32'h0000_0055;
        for (int k = 0; k < 8; k++) begin
            probe();
            chkb("t2_svalid", s_valid, k % 2 == 1);
            chkb("t2_m0_ready", m0_ready, k % 4 == 1);
            chkb("t2_m1_ready", m1_ready, k % 4 == 3);
            if (k % 2 == 1) chk("t2_addr", s_addr, (k % 4 == 1) ? 32'h200 : 32'h300);
            tick();
        end
        m0_valid = 1'b0; m0_instr = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        probe(); chkb("t2_idle", s_valid, 1'b0);
        tick();

        // m1 write to the UART address
        m1_valid = 1'b1; m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
        probe(); tick();
        probe();
        chkb("t3_svalid", s_valid, 1'b1);
        chk("t3_addr", s_addr, 32'h1000_0000);
        chk("t3_wdata", s_wdata, 32'h41);
        chk("t3_wstrb", {28'b0, s_wstrb}, 32'h1);
        chkb("t3_instr", s_instr, 1'b0);
        tick();
        s_ready = 1'b1;
        probe(); chkb("t3_m1_ready", m1_ready, 1'b1); chkb("t3_m0_ready", m0_ready, 1'b0);
        tick();
        m1_valid = 1'b0; m1_wstrb = '0; m1_wdata = '0; s_ready = 1'b0; s_rdata = '0;
        probe(); tick();

        // slave never answers: forced completion on the 8th BUSY cycle
        m0_valid = 1'b1; m0_addr = 32'h400;
        probe(); tick();
        for (int i = 0; i < TO; i++) begin
            probe();
            chkb("t4_m0_ready", m0_ready, i == TO - 1);
            chkb("t4_timeout", timeout_err, i == TO - 1);
            chkb("t4_svalid", s_valid, i != TO - 1);
            chk("t4_rdata", m0_rdata, (i == TO - 1) ? ERR : 32'h0);
            tick();
        end
        m0_valid = 1'b0;
        probe(); chkb("t4_idle_timeout", timeout_err, 1'b0); chkb("t4_idle_svalid", s_valid, 1'b0);
        tick();

        // ready arrives on the limit cycle: normal completion wins
        m0_valid = 1'b1; m0_addr = 32'h500; s_rdata = 32'hCAFE_F00D;
        probe(); tick();
        for (int i = 0; i < TO; i++) begin
            s_ready = (i == TO - 1);
            probe();
            chkb("t5_m0_ready", m0_ready, i == TO - 1);
            chkb("t5_timeout", timeout_err, 1'b0);
            chk("t5_rdata", m0_rdata, 32'hCAFE_F00D);
            tick();
        end
        m0_valid = 1'b0; s_ready = 1'b0;
        probe(); tick();

        // reset during BUSY1, then the next tie goes to m0
        m0_valid = 1'b1; m0_addr = 32'h600; m1_valid = 1'b1; m1_addr = 32'h700;
        probe(); tick();
        probe(); chk("t6_m1_granted", s_addr, 32'h700); chkb("t6_svalid", s_valid, 1'b1);
        tick();
        resetn = 1'b0; s_ready = 1'b1;
        probe(); chkb("t6_rst_m1_ready", m1_ready, 1'b0); chkb("t6_rst_svalid", s_valid, 1'b0);
        tick();
        resetn = 1'b1; s_ready = 1'b0;
        probe(); chkb("t6_idle_svalid", s_valid, 1'b0); chkb("t6_idle_m1_ready", m1_ready, 1'b0);
        tick();
        probe(); chk("t6_tie_m0", s_addr, 32'h600); chkb("t6_tie_svalid", s_valid, 1'b1);
        tick();

        // m0 drops its request mid-transaction: s_valid follows immediately, no error
        m0_valid = 1'b0;
        probe(); chkb("t7_svalid", s_valid, 1'b0); chkb("t7_timeout", timeout_err, 1'b0);
        tick();
        m1_valid = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
